// File: rtl/offset_cmp_monitor.sv
// Offset-sum threshold monitor: raises an alarm after HIT_LEN consecutive hits, then
// emits one event record (peak hit sum and source channels) and cools down for HOLD_LEN quiet samples.
module offset_cmp_monitor #(
  parameter int unsigned HIT_LEN  = 3,
  parameter int unsigned HOLD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] sum_a,
  input  logic       hit_a,
  input  logic [4:0] sum_b,
  input  logic       hit_b,
  output logic       alarm,
  output logic [2:0] run_cnt,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_peak,
  output logic [1:0] evt_src
);

  localparam logic [2:0] HitLen  = HIT_LEN[2:0];
  localparam logic [2:0] HoldLen = HOLD_LEN[2:0];

  typedef enum logic [1:0] {StIdle, StRun, StAlarm, StHold} state_e;

  state_e     state_q, state_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic [4:0] peak_q, peak_d;
  logic [1:0] src_q, src_d;
  logic       alarm_q, alarm_d;
  logic       evt_valid_q, evt_valid_d;
  logic [4:0] evt_peak_q, evt_peak_d;
  logic [1:0] evt_src_q, evt_src_d;

  logic       hit;
  logic       accept;
  logic [4:0] sum_a_m, sum_b_m, hsum, peak_max;

  assign in_ready  = !evt_valid_q;
  assign alarm     = alarm_q;
  assign run_cnt   = run_cnt_q;
  assign evt_valid = evt_valid_q;
  assign evt_peak  = evt_peak_q;
  assign evt_src   = evt_src_q;

  always_comb begin
    hit      = hit_a | hit_b;
    accept   = in_valid && !evt_valid_q;
    sum_a_m  = hit_a ? sum_a : 5'd0;
    sum_b_m  = hit_b ? sum_b : 5'd0;
    hsum     = (sum_a_m > sum_b_m) ? sum_a_m : sum_b_m;
    peak_max = (hsum > peak_q) ? hsum : peak_q;
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    peak_d      = peak_q;
    src_d       = src_q;
    evt_peak_d  = evt_peak_q;
    evt_src_d   = evt_src_q;
    evt_valid_d = evt_valid_q && !evt_ready;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            run_cnt_d = 3'd1;
            peak_d    = hsum;
            src_d     = {hit_b, hit_a};
            state_d   = (HitLen == 3'd1) ? StAlarm : StRun;
          end
        end
        StRun: begin
          if (hit) begin
            run_cnt_d = run_cnt_q + 3'd1;
            peak_d    = peak_max;
            src_d     = src_q | {hit_b, hit_a};
            if (run_cnt_q + 3'd1 == HitLen) state_d = StAlarm;
          end else begin
            state_d   = StIdle;
            run_cnt_d = 3'd0;
            peak_d    = 5'd0;
            src_d     = 2'd0;
          end
        end
        StAlarm: begin
          if (hit) begin
            peak_d = peak_max;
            src_d  = src_q | {hit_b, hit_a};
          end else begin
            run_cnt_d   = 3'd0;
            evt_valid_d = 1'b1;
            evt_peak_d  = peak_q;
            evt_src_d   = src_q;
            peak_d      = 5'd0;
            src_d       = 2'd0;
            // The alarm-ending sample already counts as the first quiet sample.
            if (HoldLen == 3'd1) begin
              state_d    = StIdle;
              hold_cnt_d = 3'd0;
            end else begin
              state_d    = StHold;
              hold_cnt_d = 3'd1;
            end
          end
        end
        StHold: begin
          if (hit) begin
            hold_cnt_d = 3'd0;
          end else if (hold_cnt_q + 3'd1 == HoldLen) begin
            state_d    = StIdle;
            hold_cnt_d = 3'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    alarm_d = (state_d == StAlarm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      run_cnt_q   <= 3'd0;
      hold_cnt_q  <= 3'd0;
      peak_q      <= 5'd0;
      src_q       <= 2'd0;
      alarm_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_peak_q  <= 5'd0;
      evt_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      peak_q      <= peak_d;
      src_q       <= src_d;
      alarm_q     <= alarm_d;
      evt_valid_q <= evt_valid_d;
      evt_peak_q  <= evt_peak_d;
      evt_src_q   <= evt_src_d;
    end
  end

endmodule

// File: tb/tb_offset_cmp_monitor.sv
// Bench for offset_cmp_monitor: directed scenarios plus randomized traffic checked against
// a behavioural model of hit runs, alarm, cooldown and the pending event record.
module tb_offset_cmp_monitor;

  localparam int HitN  = 3;
  localparam int HoldN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] sum_a = 5'd0;
  logic       hit_a = 1'b0;
  logic [4:0] sum_b = 5'd0;
  logic       hit_b = 1'b0;
  logic       evt_ready = 1'b0;

  logic       in_ready, alarm, evt_valid;
  logic [2:0] run_cnt;
  logic [4:0] evt_peak;
  logic [1:0] evt_src;

  logic       in_ready1, alarm1, evt_valid1;
  logic [2:0] run_cnt1;
  logic [4:0] evt_peak1;
  logic [1:0] evt_src1;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the default-parameter instance.
  int m_run, m_peak, m_src, m_alarm, m_cool, m_quiet, m_ev, m_evpeak, m_evsrc;

  always #5 clk = ~clk;

  offset_cmp_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_a(sum_a), .hit_a(hit_a), .sum_b(sum_b), .hit_b(hit_b),
    .alarm(alarm), .run_cnt(run_cnt), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_peak(evt_peak), .evt_src(evt_src)
  );

  offset_cmp_monitor #(.HIT_LEN(1), .HOLD_LEN(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .sum_a(sum_a), .hit_a(hit_a), .sum_b(sum_b), .hit_b(hit_b),
    .alarm(alarm1), .run_cnt(run_cnt1), .evt_valid(evt_valid1), .evt_ready(evt_ready),
    .evt_peak(evt_peak1), .evt_src(evt_src1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic iv, input int sa, input int ha,
                            input int sb, input int hb, input logic er);
    int h, hs, pa, pb;
    logic acc;
    if (r) begin
      m_run = 0; m_peak = 0; m_src = 0; m_alarm = 0; m_cool = 0; m_quiet = 0;
      m_ev = 0; m_evpeak = 0; m_evsrc = 0;
      return;
    end
    acc = iv && (m_ev == 0);
    if (m_ev != 0 && er) m_ev = 0;
    if (!acc) return;
    h  = ha | hb;
    pa = ha ? sa : 0;
    pb = hb ? sb : 0;
    hs = (pa > pb) ? pa : pb;
    if (m_cool != 0) begin
      if (h != 0) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet >= HoldN) m_cool = 0;
      end
    end else if (h != 0) begin
      if (m_run == 0) begin
        m_peak = hs;
        m_src  = hb * 2 + ha;
      end else begin
        m_peak = (hs > m_peak) ? hs : m_peak;
        m_src  = m_src | (hb * 2 + ha);
      end
      if (m_run < HitN) m_run++;
      if (m_run == HitN) m_alarm = 1;
    end else begin
      if (m_alarm != 0) begin
        m_ev = 1; m_evpeak = m_peak; m_evsrc = m_src;
        m_alarm = 0; m_cool = (HoldN > 1); m_quiet = 1;
      end
      m_run = 0; m_peak = 0; m_src = 0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare every default-instance output.
  task automatic step(input logic r, input logic iv, input int sa, input int ha,
                      input int sb, input int hb, input logic er);
    rst = r; in_valid = iv; sum_a = 5'(sa); hit_a = ha[0]; sum_b = 5'(sb); hit_b = hb[0];
    evt_ready = er;
    model_step(r, iv, sa, ha, sb, hb, er);
    @(posedge clk);
    #1;
    check("alarm", 32'(alarm), 32'(m_alarm));
    check("run_cnt", 32'(run_cnt), 32'(m_run));
    check("evt_valid", 32'(evt_valid), 32'(m_ev));
    check("evt_peak", 32'(evt_peak), 32'(m_evpeak));
    check("evt_src", 32'(evt_src), 32'(m_evsrc));
    check("in_ready", 32'(in_ready), 32'(m_ev == 0));
  endtask

  task automatic seq_basic();
    step(0, 1, 5, 1, 0, 0, 0);
    step(0, 1, 9, 1, 3, 1, 0);
    step(0, 1, 2, 0, 7, 1, 0);
    check("basic_alarm", 32'(alarm), 32'd1);
    check("basic_run_cnt", 32'(run_cnt), 32'd3);
    step(0, 1, 0, 0, 0, 0, 0);
    check("basic_alarm_off", 32'(alarm), 32'd0);
    check("basic_evt_valid", 32'(evt_valid), 32'd1);
    check("basic_evt_peak", 32'(evt_peak), 32'd9);
    check("basic_evt_src", 32'(evt_src), 32'd3);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alarm", 32'(alarm), 32'd0);

    // Basic alarm and event
    seq_basic();

    // Two hits then a quiet sample: no alarm
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 1, 0, 0, 0);
    check("short_run1", 32'(run_cnt), 32'd1);
    step(0, 1, 0, 0, 6, 1, 0);
    check("short_run2", 32'(run_cnt), 32'd2);
    step(0, 1, 0, 0, 0, 0, 0);
    check("short_run0", 32'(run_cnt), 32'd0);
    check("short_no_alarm", 32'(alarm), 32'd0);
    check("short_no_evt", 32'(evt_valid), 32'd0);

    // Back-pressure: event pending blocks input for 5 cycles
    seq_basic();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 20 + i, 1, 1, 1, 0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_peak_stable", 32'(evt_peak), 32'd9);
      check("bp_src_stable", 32'(evt_src), 32'd3);
    end
    // Consumed in the same cycle as a valid sample: sample is not accepted
    step(0, 1, 30, 1, 0, 0, 1);
    check("consume_evt_valid", 32'(evt_valid), 32'd0);
    check("consume_in_ready", 32'(in_ready), 32'd1);

    // Cooldown: one quiet already counted, another quiet, a hit, then 4 quiet samples
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 11, 1, 0, 0, 0);
    check("hold_hit_no_run", 32'(run_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 12, 1, 0, 0, 0);
    check("hold_still_cool", 32'(run_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      check("hold_no_alarm", 32'(alarm), 32'd0);
    end
    step(0, 1, 12, 1, 0, 0, 0);
    check("hold_back_idle", 32'(run_cnt), 32'd1);

    // HIT_LEN=1 instance
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 31, 1, 0);
    check("h1_alarm", 32'(alarm1), 32'd1);
    check("h1_run_cnt", 32'(run_cnt1), 32'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("h1_alarm_off", 32'(alarm1), 32'd0);
    check("h1_evt_valid", 32'(evt_valid1), 32'd1);
    check("h1_evt_peak", 32'(evt_peak1), 32'd31);
    check("h1_evt_src", 32'(evt_src1), 32'd2);

    // Reset with an event pending discards everything
    step(1, 0, 0, 0, 0, 0, 0);
    seq_basic();
    step(1, 1, 17, 1, 17, 1, 1);
    check("rst_pend_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_pend_evt_peak", 32'(evt_peak), 32'd0);
    check("rst_pend_in_ready", 32'(in_ready), 32'd1);
    seq_basic();

    // Randomized traffic
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 9) < 6),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/offset_cmp_monitor.md
OFFSET_CMP_MONITOR -- requirements
Module: offset_cmp_monitor

Interface
REQ-001 SHALL have parameter HIT_LEN, default 3, consecutive hit samples needed to raise alarm (legal 1..7).
REQ-002 SHALL have parameter HOLD_LEN, default 4, consecutive non-hit samples needed to leave cooldown (legal 1..7).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  sample present.
REQ-006 SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-007 SHALL have port sum_a  input  5  unsigned offset sum, channel A.
REQ-008 SHALL have port hit_a  input  1  threshold-compare flag, channel A.
REQ-009 SHALL have port sum_b  input  5  unsigned offset sum, channel B.
REQ-010 SHALL have port hit_b  input  1  threshold-compare flag, channel B.
REQ-011 SHALL have port alarm  output  1  high while in ALARM.
REQ-012 SHALL have port run_cnt  output  3  current consecutive-hit count.
REQ-013 SHALL have port evt_valid  output  1  event record pending.
REQ-014 SHALL have port evt_ready  input  1  consumer takes event when evt_valid && evt_ready.
REQ-015 SHALL have port evt_peak  output  5  max hit sum over the alarm run.
REQ-016 SHALL have port evt_src  output  2  bit0 = A hit seen in run, bit1 = B hit seen in run.

Function
REQ-017 SHALL define hit = hit_a | hit_b and hsum = max(hit_a ? sum_a : 0, hit_b ? sum_b : 0), unsigned 5-bit compare; only accepted samples affect state.
REQ-018 SHALL implement FSM states IDLE, RUN, ALARM, HOLD; all outputs registered, one-cycle latency from accepting edge.
REQ-019 IDLE: accepted hit -> run_cnt=1, peak=hsum, src={hit_b,hit_a}; next state ALARM if HIT_LEN==1, else RUN; accepted non-hit -> stay IDLE.
REQ-020 RUN: accepted hit -> run_cnt+1, peak=max(peak,hsum), src|= flags; ALARM when new run_cnt==HIT_LEN; accepted non-hit -> IDLE, run_cnt=0, peak/src cleared.
REQ-021 ALARM: alarm=1; accepted hit -> update peak/src, run_cnt saturates at HIT_LEN; accepted non-hit -> HOLD, run_cnt=0, hold count=1, evt_valid=1 with evt_peak/evt_src loaded from run.
REQ-022 HOLD: alarm=0; accepted non-hit -> hold count+1, IDLE when it reaches HOLD_LEN; accepted hit -> hold count reset to 0, no new run started.
REQ-023 evt_peak/evt_src SHALL be stable while evt_valid=1; evt_valid clears on the edge where evt_ready=1.
REQ-024 in_ready SHALL equal !evt_valid (no sample accepted while an event is pending, so a second event can never overwrite the first).
REQ-025 in_valid low or in_ready low SHALL freeze all state except evt_valid clearing.
REQ-026 evt_ready while evt_valid=0 SHALL have no effect.
REQ-027 Event consumed in the same cycle as in_valid=1 SHALL NOT accept that sample (in_ready is registered-state based, low that cycle).

Reset
REQ-028 rst=1 SHALL force IDLE, alarm=0, run_cnt=0, evt_valid=0, evt_peak=0, evt_src=0, hold count=0, in_ready=1 on next edge.
REQ-029 rst mid-run, mid-ALARM or with an event pending SHALL discard all progress and the pending event; rst overrides all other inputs.

Verification
REQ-030 Defaults; hits with (sum_a,hit_a,sum_b,hit_b) = (5,1,0,0),(9,1,3,1),(2,0,7,1) -> alarm=1 after third accept, run_cnt=3; then non-hit -> alarm=0, evt_valid=1, evt_peak=9, evt_src=2'b11.
REQ-031 Two hits then non-hit -> run_cnt 1,2,0, state IDLE, alarm never set, evt_valid stays 0.
REQ-032 Event pending with evt_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, evt_peak/evt_src unchanged; evt_ready=1 -> evt_valid=0, in_ready=1 next cycle.
REQ-033 HOLD: non-hit, non-hit, hit, then 4 non-hits -> returns to IDLE only after the 4 non-hits following the hit; no alarm during HOLD.
REQ-034 HIT_LEN=1: single hit sum_b=31 -> ALARM directly; non-hit -> evt_peak=31, evt_src=2'b10.
REQ-035 rst asserted during ALARM with event pending -> all outputs zero, in_ready=1 next cycle; fresh run then behaves as REQ-030.
